program_loader: RTL



---
 rtl/program_loader_if.sv | 29 ++
 rtl/program_loader.sv | 120 ++++++++++++
 2 files changed

// File: rtl/program_loader_if.sv
// Byte-input, memory-write and status signals between the program loader and its neighbours.
// The loader sits on the slave side; the UART/fetch/pipeline environment is the master.
interface program_loader_if #(
    parameter int unsigned NBITS  = 32,
    parameter int unsigned ADDR_W = 10
);
    logic [7:0]        i_rx_data;
    logic              i_rx_valid;
    logic              i_start;
    logic              o_inst_mem_wr_en;
    logic [ADDR_W-1:0] o_inst_mem_addr;
    logic [NBITS-1:0]  o_inst_mem_data;
    logic              o_cpu_en;
    logic              o_busy;
    logic [ADDR_W:0]   o_word_count;
    logic              o_overflow;

    modport slave (
        input  i_rx_data, i_rx_valid, i_start,
        output o_inst_mem_wr_en, o_inst_mem_addr, o_inst_mem_data,
        output o_cpu_en, o_busy, o_word_count, o_overflow
    );

    modport master (
        output i_rx_data, i_rx_valid, i_start,
        input  o_inst_mem_wr_en, o_inst_mem_addr, o_inst_mem_data,
        input  o_cpu_en, o_busy, o_word_count, o_overflow
    );
endinterface

// File: rtl/program_loader.sv
// Assembles UART bytes little-endian into instruction words, writes them sequentially into
// instruction memory, and releases the CPU once the HALT word has been stored.
module program_loader #(
    parameter int unsigned     NBITS     = 32,
    parameter int unsigned     ADDR_W    = 10,
    parameter logic [NBITS-1:0] HALT_WORD = {NBITS{1'b1}}
) (
    input  logic             i_clk,
    input  logic             i_rst,
    program_loader_if.slave  bus
);

    localparam int unsigned       NBytes   = NBITS / 8;
    localparam int unsigned       ByteW    = (NBytes > 1) ? $clog2(NBytes) : 1;
    localparam logic [ByteW-1:0]  LastByte = ByteW'(NBytes - 1);
    localparam logic [ADDR_W-1:0] LastAddr = '1;

    typedef enum logic [2:0] {StIdle, StLoad, StWrite, StDone, StError} state_e;

    state_e            state_q, state_d;
    logic [ByteW-1:0]  byte_cnt_q, byte_cnt_d;
    logic [NBITS-1:0]  asm_q, asm_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NBITS-1:0]  data_q, data_d;
    logic              cpu_en_q, cpu_en_d;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;
    logic              byte_ok;
    logic              word_done;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        count_d    = count_q;
        wr_en_d    = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;

        // Bytes are accepted in WRITE too, so back-to-back words never lose a byte.
        byte_ok   = bus.i_rx_valid && (state_q == StLoad || state_q == StWrite);
        word_done = byte_ok && (byte_cnt_q == LastByte);

        if (byte_ok) begin
            asm_d      = {bus.i_rx_data, asm_q[NBITS-1:8]};
            byte_cnt_d = word_done ? '0 : byte_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (bus.i_start) begin
                    state_d    = StLoad;
                    count_d    = '0;
                    byte_cnt_d = '0;
                end
            end
            StLoad: begin
                if (word_done) begin
                    state_d = StWrite;
                    wr_en_d = 1'b1;
                    addr_d  = count_q[ADDR_W-1:0];
                    data_d  = {bus.i_rx_data, asm_q[NBITS-1:8]};
                end
            end
            StWrite: begin
                count_d = count_q + 1'b1;
                // HALT takes priority so a HALT in the last slot still counts as a clean load.
                if (data_q == HALT_WORD) begin
                    state_d = StDone;
                end else if (addr_q == LastAddr) begin
                    state_d = StError;
                end else begin
                    state_d = StLoad;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d     = (state_d == StLoad) || (state_d == StWrite);
        cpu_en_d   = (state_d == StDone);
        overflow_d = (state_d == StError);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            count_q    <= '0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            cpu_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            count_q    <= count_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            cpu_en_q   <= cpu_en_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.o_inst_mem_wr_en = wr_en_q;
    assign bus.o_inst_mem_addr  = addr_q;
    assign bus.o_inst_mem_data  = data_q;
    assign bus.o_cpu_en         = cpu_en_q;
    assign bus.o_busy           = busy_q;
    assign bus.o_word_count     = count_q;
    assign bus.o_overflow       = overflow_q;

endmodule
